register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp.sv | 157 +++++++++++++++
 tb/tb_register_file_mp.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// -----------------------------------------------------------------------------
// register_file_mp
// Multi-read-port register file with a single write port, optional hardwired
// zero register, optional write-to-read forwarding and a sequential clear
// engine that walks the whole array writing zeros, one entry per cycle.
//
// Ports
//   clk               single clock, all state changes on its rising edge
//   reset             asynchronous active-low reset (zeros array, FSM to IDLE)
//   reg_write_i       write enable
//   write_register_i  write address            [SIZE-1:0]
//   write_data_i      write data               [WIDTH-1:0]
//   read_register_i   packed read addresses    port k -> [k*SIZE +: SIZE]
//   read_data_o       packed read data         port k -> [k*WIDTH +: WIDTH]
//   clear_i           request to zero the whole array (accepted in IDLE only)
//   busy_o            high while the clear sequencer is walking the array
//   clear_done_o      one-cycle pulse in the cycle after the last entry clears
// -----------------------------------------------------------------------------
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     reg_write_i,
  input  logic [SIZE-1:0]          write_register_i,
  input  logic [WIDTH-1:0]         write_data_i,
  input  logic [NUM_READ*SIZE-1:0] read_register_i,
  output logic [NUM_READ*WIDTH-1:0] read_data_o,
  input  logic                     clear_i,
  output logic                     busy_o,
  output logic                     clear_done_o
);

  localparam int              DEPTH    = 1 << SIZE;
  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(DEPTH - 1);
  localparam logic [SIZE-1:0] ONE      = SIZE'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [DEPTH];

  logic clear_accept;
  logic write_open;
  logic write_en;

  // A clear request only starts a sequence from IDLE; in DONE it is ignored.
  assign clear_accept = (state_q == IDLE) && clear_i;

  // Write is qualified outside CLEAR, never on the edge that accepts a clear,
  // and never while reset is held (also keeps forwarding quiet during reset).
  assign write_open = reset && reg_write_i &&
                      ((state_q == IDLE) || (state_q == DONE)) &&
                      !clear_accept;

  // Address 0 is never stored when it is the hardwired zero register.
  assign write_en = write_open &&
                    !((ZERO_REG != 0) && (write_register_i == '0));

  // ---------------------------------------------------------------------------
  // Clear FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        // The counter returns to 0 on the final entry instead of wrapping
        // through, so it is already parked for the next clear.
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy_o       = (state_q == CLEAR);
  assign clear_done_o = (state_q == DONE);

  // ---------------------------------------------------------------------------
  // Storage array. Asynchronous reset zeros every entry, so this maps to
  // flops rather than block RAM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (state_q == CLEAR) begin
      regs_q[cnt_q] <= '0;
    end else if (write_en) begin
      regs_q[write_register_i] <= write_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read ports. Zero-register rule beats forwarding; forwarding
  // is inherently off in CLEAR because write_open is low there.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [SIZE-1:0] rd_addr;
      logic            rd_zero;
      logic            rd_fwd;

      assign rd_addr = read_register_i[gi*SIZE +: SIZE];
      assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);
      assign rd_fwd  = (BYPASS != 0) && write_open &&
                       (rd_addr == write_register_i);

      assign read_data_o[gi*WIDTH +: WIDTH] =
          rd_zero ? '0 :
          rd_fwd  ? write_data_i :
                    regs_q[rd_addr];
    end
  endgenerate

endmodule

// File: tb/tb_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_register_file_mp
// Directed bench for register_file_mp. Two instances share all inputs: one
// with forwarding enabled (default parameters) and one with BYPASS=0. Expected
// read values are queued when a read is set up and compared when sampled.
// -----------------------------------------------------------------------------
module tb_register_file_mp;

  localparam int W = 32;
  localparam int S = 5;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           reg_write = 1'b0;
  logic [S-1:0]   waddr = '0;
  logic [W-1:0]   wdata = '0;
  logic [N*S-1:0] raddr = '0;
  logic           clear = 1'b0;
  logic [N*W-1:0] rdata, rdata_nb;
  logic           busy, done, busy_nb, done_nb;

  always #5 clk = ~clk;

  register_file_mp #(.WIDTH(W), .SIZE(S), .NUM_READ(N), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .reg_write_i      (reg_write),
    .write_register_i (waddr),
    .write_data_i     (wdata),
    .read_register_i  (raddr),
    .read_data_o      (rdata),
    .clear_i          (clear),
    .busy_o           (busy),
    .clear_done_o     (done)
  );

  register_file_mp #(.WIDTH(W), .SIZE(S), .NUM_READ(N), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk              (clk),
    .reset            (reset),
    .reg_write_i      (reg_write),
    .write_register_i (waddr),
    .write_data_i     (wdata),
    .read_register_i  (raddr),
    .read_data_o      (rdata_nb),
    .clear_i          (clear),
    .busy_o           (busy_nb),
    .clear_done_o     (done_nb)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        tag;
    int           port;
    bit           nb;
    logic [W-1:0] exp;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Point a read port at an address and queue the value it must return.
  task automatic read_expect(input string tag, input int port, input logic [S-1:0] addr,
                             input logic [W-1:0] exp, input bit nb = 1'b0);
    raddr[port*S +: S] = addr;
    sb.push_back('{tag, port, nb, exp});
  endtask

  // Let reads settle, then compare every queued expectation.
  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.nb ? rdata_nb[e.port*W +: W] : rdata[e.port*W +: W], e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [S-1:0] a, input logic [W-1:0] d);
    reg_write = 1'b1;
    waddr     = a;
    wdata     = d;
    step();
    reg_write = 1'b0;
  endtask

  initial begin
    int c;

    // ---- reset state; writes inhibited while reset is low ----
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reg_write = 1'b1; waddr = 5'd9; wdata = 32'h99;
    read_expect("rst_r2", 0, 5'd2, 0);
    read_expect("rst_fwd9", 1, 5'd9, 0);
    drain();
    step();
    reg_write = 1'b0;
    reset = 1'b1;
    read_expect("rst_w9_dropped", 1, 5'd9, 0);
    drain();

    // ---- basic writes then reads on both ports ----
    write(5'd2, 32'd7);
    write(5'd4, 32'd20);
    read_expect("wr_p0_r2", 0, 5'd2, 32'd7);
    read_expect("wr_p1_r4", 1, 5'd4, 32'd20);
    read_expect("wr_nb_p0_r2", 0, 5'd2, 32'd7, 1'b1);
    read_expect("wr_nb_p1_r4", 1, 5'd4, 32'd20, 1'b1);
    drain();

    // ---- zero register: write discarded, no forwarding of address 0 ----
    reg_write = 1'b1; waddr = 5'd0; wdata = 32'd3;
    read_expect("z_fwd_p0", 0, 5'd0, 0);
    read_expect("z_fwd_p1", 1, 5'd0, 0);
    drain();
    step();
    reg_write = 1'b0;
    read_expect("z_p0", 0, 5'd0, 0);
    read_expect("z_p1", 1, 5'd0, 0);
    read_expect("z_nb_p0", 0, 5'd0, 0, 1'b1);
    drain();

    // ---- same-cycle forwarding vs. no forwarding ----
    reg_write = 1'b1; waddr = 5'd19; wdata = 32'd78;
    read_expect("byp_p1_r19", 1, 5'd19, 32'd78);
    read_expect("nobyp_p1_r19", 1, 5'd19, 0, 1'b1);
    drain();
    step();
    reg_write = 1'b0;
    read_expect("post_p1_r19", 1, 5'd19, 32'd78);
    read_expect("post_nb_p1_r19", 1, 5'd19, 32'd78, 1'b1);
    drain();

    // ---- fill 1..31 with their index ----
    for (int i = 1; i < 32; i++) write(S'(i), W'(i));
    read_expect("fill_r19", 0, 5'd19, 32'd19);
    read_expect("fill_r4", 1, 5'd4, 32'd4);
    drain();

    // ---- clear accepted together with a write to reg 31: write dropped ----
    clear = 1'b1; reg_write = 1'b1; waddr = 5'd31; wdata = 32'd6;
    read_expect("clr_acc_nofwd31", 1, 5'd31, 32'd31);
    drain();
    step();
    // clear_i stays high and writes keep coming during CLEAR: both ignored
    waddr = 5'd3; wdata = 32'hdead;
    c = 0;
    while (busy === 1'b1 && c < 100) begin
      read_expect("clr_r3", 0, 5'd3, (c > 3) ? 32'd0 : 32'd3);
      read_expect("clr_r31", 1, 5'd31, 32'd31);
      drain();
      step();
      c++;
    end
    chk("busy_cycles", c, 32);
    // now in DONE: one-cycle pulse, writes accepted, clear ignored
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    waddr = 5'd7; wdata = 32'h77;
    step();
    reg_write = 1'b0;
    clear = 1'b0;
    chk("done_gone", done, 0);
    chk("idle_busy", busy, 0);
    for (int i = 0; i < 32; i++) begin
      read_expect("sweep_p0", 0, S'(i), (i == 7) ? 32'h77 : 32'd0);
      read_expect("sweep_p1", 1, S'(31 - i), ((31 - i) == 7) ? 32'h77 : 32'd0);
      drain();
    end

    // ---- reset mid-clear aborts the clear ----
    write(5'd20, 32'h20);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (10) step();
    chk("midclr_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    read_expect("abort_r7", 0, 5'd7, 0);
    read_expect("abort_r20", 1, 5'd20, 0);
    drain();
    reg_write = 1'b1; waddr = 5'd25; wdata = 32'h25;
    step();
    reset = 1'b1;
    step();
    reg_write = 1'b0;
    read_expect("first_wr_r25", 0, 5'd25, 32'h25);
    read_expect("after_rst_r20", 1, 5'd20, 0);
    drain();
    chk("after_rst_busy", busy, 0);
    chk("after_rst_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
